bounded_updown_counter: RTL and testbench

- Parametrised successor to the team's basic up/down counter: programmable step, runtime min/max bounds, wrap or saturate mode, synchronous load, and overflow/underflow event reporting.
- Single channel, fully synchronous. Intended for timers, pointers and position trackers in the Arty S7 fabric designs.
- Replaces ad-hoc bound-checking logic wrapped around the plain counter.

---
 rtl/bounded_updown_counter_pkg.sv | 26 ++
 rtl/bounded_updown_counter_bound_step_calc.sv | 58 +++++
 rtl/bounded_updown_counter.sv | 92 +++++++++
 tb/tb_bounded_updown_counter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bounded_updown_counter_pkg.sv
// Shared constants and helpers for the bounded up/down counter.
// clamp() works at a fixed 32-bit width; callers zero-extend and truncate.
package bounded_updown_counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int CLAMP_W = 32;

  function automatic logic [CLAMP_W-1:0] clamp(
    input logic [CLAMP_W-1:0] value,
    input logic [CLAMP_W-1:0] lo,
    input logic [CLAMP_W-1:0] hi
  );
    logic [CLAMP_W-1:0] res;
    if (value < lo) begin
      res = lo;
    end else if (value > hi) begin
      res = hi;
    end else begin
      res = value;
    end
    return res;
  endfunction

endpackage

// File: rtl/bounded_updown_counter_bound_step_calc.sv
// Combinational next-value and bound-event calculation for one step up or down.
// Arithmetic is one bit wider than the count so that no sum or limit can alias.
module bound_step_calc
  import bounded_updown_counter_pkg::*;
#(
  parameter int COUNT_WIDTH = 8,
  parameter int STEP_WIDTH  = 4
) (
  input  logic [COUNT_WIDTH-1:0] counter,
  input  logic [STEP_WIDTH-1:0]  step,
  input  logic [COUNT_WIDTH-1:0] min_val,
  input  logic [COUNT_WIDTH-1:0] max_val,
  input  logic                   sat_mode,
  output logic [COUNT_WIDTH-1:0] next_up,
  output logic [COUNT_WIDTH-1:0] next_down,
  output logic                   ovf,
  output logic                   unf
);

  localparam int EXT_W = COUNT_WIDTH + 1;

  logic [EXT_W-1:0] count_ext;
  logic [EXT_W-1:0] step_ext;
  logic [EXT_W-1:0] min_ext;
  logic [EXT_W-1:0] max_ext;
  logic [EXT_W-1:0] sum;
  logic [EXT_W-1:0] down_limit;
  logic [EXT_W-1:0] diff;

  assign count_ext  = {1'b0, counter};
  assign step_ext   = {{(EXT_W-STEP_WIDTH){1'b0}}, step};
  assign min_ext    = {1'b0, min_val};
  assign max_ext    = {1'b0, max_val};

  assign sum        = count_ext + step_ext;
  assign down_limit = min_ext + step_ext;
  assign diff       = count_ext - step_ext;

  // Only the bound in the direction of motion is checked, so an
  // out-of-range count moving back toward the range just adds/subtracts.
  assign ovf = (sum > max_ext);
  assign unf = (count_ext < down_limit);

  always_comb begin
    next_up = sum[COUNT_WIDTH-1:0];
    if (ovf) begin
      next_up = (sat_mode == MODE_SAT) ? max_val : min_val;
    end
  end

  always_comb begin
    next_down = diff[COUNT_WIDTH-1:0];
    if (unf) begin
      next_down = (sat_mode == MODE_SAT) ? min_val : max_val;
    end
  end

endmodule

// File: rtl/bounded_updown_counter.sv
// Bounded up/down counter: programmable step, runtime bounds, wrap/saturate,
// clamped load, and overflow/underflow pulse plus sticky flags.
module bounded_updown_counter
  import bounded_updown_counter_pkg::*;
#(
  parameter int                     COUNT_WIDTH = 8,
  parameter int                     STEP_WIDTH  = 4,
  parameter logic [COUNT_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                   clk,
  input  logic                   s_reset_n,
  input  logic                   enable,
  input  logic                   inc_en,
  input  logic                   dec_en,
  input  logic                   load,
  input  logic [COUNT_WIDTH-1:0] load_value,
  input  logic [STEP_WIDTH-1:0]  step,
  input  logic [COUNT_WIDTH-1:0] min_val,
  input  logic [COUNT_WIDTH-1:0] max_val,
  input  logic                   sat_mode,
  input  logic                   clear_flags,
  output logic [COUNT_WIDTH-1:0] counter,
  output logic                   at_max,
  output logic                   at_min,
  output logic                   bound_pulse,
  output logic                   ovf_sticky,
  output logic                   unf_sticky,
  output logic                   cfg_err
);

  logic [COUNT_WIDTH-1:0] next_up;
  logic [COUNT_WIDTH-1:0] next_down;
  logic                   ovf;
  logic                   unf;
  logic [COUNT_WIDTH-1:0] load_clamped;
  logic                   count_up;
  logic                   count_down;
  logic                   ovf_evt;
  logic                   unf_evt;

  bound_step_calc #(
    .COUNT_WIDTH (COUNT_WIDTH),
    .STEP_WIDTH  (STEP_WIDTH)
  ) u_step_calc (
    .counter   (counter),
    .step      (step),
    .min_val   (min_val),
    .max_val   (max_val),
    .sat_mode  (sat_mode),
    .next_up   (next_up),
    .next_down (next_down),
    .ovf       (ovf),
    .unf       (unf)
  );

  assign cfg_err = (min_val > max_val);
  assign at_max  = (counter == max_val);
  assign at_min  = (counter == min_val);

  assign load_clamped = COUNT_WIDTH'(clamp(CLAMP_W'(load_value),
                                           CLAMP_W'(min_val),
                                           CLAMP_W'(max_val)));

  // Counting is suppressed by a bad config, a load, opposing requests or a zero step.
  assign count_up   = !cfg_err && !load && enable && inc_en && !dec_en && (step != '0);
  assign count_down = !cfg_err && !load && enable && dec_en && !inc_en && (step != '0);

  assign ovf_evt = count_up   && ovf;
  assign unf_evt = count_down && unf;

  always_ff @(posedge clk) begin
    if (!s_reset_n) begin
      counter     <= RESET_VALUE;
      bound_pulse <= 1'b0;
      ovf_sticky  <= 1'b0;
      unf_sticky  <= 1'b0;
    end else begin
      if (!cfg_err && load) begin
        counter <= load_clamped;
      end else if (count_up) begin
        counter <= next_up;
      end else if (count_down) begin
        counter <= next_down;
      end
      bound_pulse <= ovf_evt || unf_evt;
      // A new event wins over a simultaneous clear.
      ovf_sticky  <= ovf_evt || (ovf_sticky && !clear_flags);
      unf_sticky  <= unf_evt || (unf_sticky && !clear_flags);
    end
  end

endmodule

// File: tb/tb_bounded_updown_counter.sv
// Directed testbench for bounded_updown_counter with hand-computed expectations.
module tb_bounded_updown_counter;

  localparam int CW = 8;
  localparam int SW = 4;

  logic          clk;
  logic          s_reset_n;
  logic          enable;
  logic          inc_en;
  logic          dec_en;
  logic          load;
  logic [CW-1:0] load_value;
  logic [SW-1:0] step;
  logic [CW-1:0] min_val;
  logic [CW-1:0] max_val;
  logic          sat_mode;
  logic          clear_flags;
  logic [CW-1:0] counter;
  logic          at_max;
  logic          at_min;
  logic          bound_pulse;
  logic          ovf_sticky;
  logic          unf_sticky;
  logic          cfg_err;

  int n_asserts = 0;
  int n_fail    = 0;

  bounded_updown_counter #(
    .COUNT_WIDTH (CW),
    .STEP_WIDTH  (SW),
    .RESET_VALUE (8'd0)
  ) dut (
    .clk         (clk),
    .s_reset_n   (s_reset_n),
    .enable      (enable),
    .inc_en      (inc_en),
    .dec_en      (dec_en),
    .load        (load),
    .load_value  (load_value),
    .step        (step),
    .min_val     (min_val),
    .max_val     (max_val),
    .sat_mode    (sat_mode),
    .clear_flags (clear_flags),
    .counter     (counter),
    .at_max      (at_max),
    .at_min      (at_min),
    .bound_pulse (bound_pulse),
    .ovf_sticky  (ovf_sticky),
    .unf_sticky  (unf_sticky),
    .cfg_err     (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [CW-1:0] c, input logic p,
                             input logic o, input logic u);
    check({tag, ".counter"}, 32'(counter), 32'(c));
    check({tag, ".pulse"},   32'(bound_pulse), 32'(p));
    check({tag, ".ovf"},     32'(ovf_sticky), 32'(o));
    check({tag, ".unf"},     32'(unf_sticky), 32'(u));
  endtask

  initial begin
    s_reset_n   = 1'b0;
    enable      = 1'b0;
    inc_en      = 1'b0;
    dec_en      = 1'b0;
    load        = 1'b0;
    load_value  = '0;
    step        = 4'd1;
    min_val     = 8'd0;
    max_val     = 8'd9;
    sat_mode    = 1'b0;
    clear_flags = 1'b0;
    tick();
    tick();
    check_state("reset", 8'd0, 1'b0, 1'b0, 1'b0);
    check("reset.at_min", 32'(at_min), 32'd1);
    check("reset.at_max", 32'(at_max), 32'd0);
    check("reset.cfg_err", 32'(cfg_err), 32'd0);

    // Test 1: wrap 0..9 -> 0
    s_reset_n = 1'b1;
    enable    = 1'b1;
    inc_en    = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("t1.counter", 32'(counter), (i == 10) ? 32'd0 : 32'(i));
      check("t1.pulse", 32'(bound_pulse), (i == 10) ? 32'd1 : 32'd0);
      if (i == 9) check("t1.at_max", 32'(at_max), 32'd1);
    end
    inc_en = 1'b0;
    tick();
    check_state("t1.after", 8'd0, 1'b0, 1'b1, 1'b0);

    // Test 2: saturate, overflow then underflow
    min_val     = 8'd10;
    max_val     = 8'd20;
    step        = 4'd4;
    sat_mode    = 1'b1;
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    check("t2.clear.ovf", 32'(ovf_sticky), 32'd0);
    load       = 1'b1;
    load_value = 8'd18;
    tick();
    load = 1'b0;
    check_state("t2.load18", 8'd18, 1'b0, 1'b0, 1'b0);
    inc_en = 1'b1;
    tick();
    inc_en = 1'b0;
    check_state("t2.inc_sat", 8'd20, 1'b1, 1'b1, 1'b0);
    tick();
    check("t2.pulse_one_cycle", 32'(bound_pulse), 32'd0);
    dec_en = 1'b1;
    tick();
    check_state("t2.dec16", 8'd16, 1'b0, 1'b1, 1'b0);
    tick();
    check_state("t2.dec12", 8'd12, 1'b0, 1'b1, 1'b0);
    tick();
    check_state("t2.dec_unf", 8'd10, 1'b1, 1'b1, 1'b1);
    dec_en = 1'b0;

    // Test 3: clamped loads
    min_val    = 8'd5;
    max_val    = 8'd250;
    load       = 1'b1;
    load_value = 8'd2;
    tick();
    check_state("t3.load_lo", 8'd5, 1'b0, 1'b1, 1'b1);
    load_value = 8'd255;
    tick();
    load = 1'b0;
    check_state("t3.load_hi", 8'd250, 1'b0, 1'b1, 1'b1);

    // Test 4: opposing requests hold; load ignores enable
    inc_en = 1'b1;
    dec_en = 1'b1;
    tick();
    check_state("t4.both", 8'd250, 1'b0, 1'b1, 1'b1);
    inc_en     = 1'b0;
    dec_en     = 1'b0;
    enable     = 1'b0;
    load       = 1'b1;
    load_value = 8'd7;
    tick();
    load   = 1'b0;
    enable = 1'b1;
    check("t4.load_noen", 32'(counter), 32'd7);

    // Test 5: config error holds everything, then set-beats-clear
    min_val = 8'd30;
    max_val = 8'd20;
    #1;
    check("t5.cfg_err", 32'(cfg_err), 32'd1);
    inc_en = 1'b1;
    tick();
    check_state("t5.hold_inc", 8'd7, 1'b0, 1'b1, 1'b1);
    inc_en     = 1'b0;
    load       = 1'b1;
    load_value = 8'd15;
    tick();
    load = 1'b0;
    check_state("t5.hold_load", 8'd7, 1'b0, 1'b1, 1'b1);
    min_val     = 8'd0;
    max_val     = 8'd9;
    sat_mode    = 1'b0;
    inc_en      = 1'b1;
    clear_flags = 1'b1;
    tick();
    inc_en = 1'b0;
    check_state("t5.set_beats_clear", 8'd0, 1'b1, 1'b1, 1'b0);
    tick();
    clear_flags = 1'b0;
    check_state("t5.clear", 8'd0, 1'b0, 1'b0, 1'b0);

    // Test 6: full range, no 8-bit alias
    min_val    = 8'd0;
    max_val    = 8'd255;
    step       = 4'd15;
    load       = 1'b1;
    load_value = 8'd250;
    tick();
    load = 1'b0;
    check("t6.load250", 32'(counter), 32'd250);
    inc_en = 1'b1;
    tick();
    check_state("t6.wrap_full", 8'd0, 1'b1, 1'b1, 1'b0);
    tick();
    check_state("t6.inc15", 8'd15, 1'b0, 1'b1, 1'b0);
    inc_en = 1'b0;
    dec_en = 1'b1;
    tick();
    check_state("t6.dec_to_min", 8'd0, 1'b0, 1'b1, 1'b0);
    tick();
    check_state("t6.unf_wrap", 8'd255, 1'b1, 1'b1, 1'b1);
    check("t6.at_max", 32'(at_max), 32'd1);
    dec_en = 1'b0;
    inc_en = 1'b1;
    step   = 4'd0;
    tick();
    check_state("t6.step0", 8'd255, 1'b0, 1'b1, 1'b1);

    // Out-of-range count: moving toward range is plain, away is an event
    clear_flags = 1'b1;
    inc_en      = 1'b0;
    tick();
    clear_flags = 1'b0;
    max_val = 8'd100;
    step    = 4'd15;
    dec_en  = 1'b1;
    tick();
    dec_en = 1'b0;
    check_state("t6.oor_down", 8'd240, 1'b0, 1'b0, 1'b0);
    inc_en = 1'b1;
    tick();
    check_state("t6.oor_up", 8'd0, 1'b1, 1'b1, 1'b0);

    // Reset beats a concurrent load
    load       = 1'b1;
    load_value = 8'd50;
    s_reset_n  = 1'b0;
    tick();
    check_state("t6.reset_over_load", 8'd0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
